// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the RV32I memory stage: opcodes, width selectors,
// exception causes, FSM states and the WriteBack entry layout.
package mem_stage_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
    } wb_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction and
// extension, and misalignment detection for the low address bits.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        sel_o       = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = shifted;
        misalign_o  = 1'b0;
        case (func3_i[1:0])
            2'b00: begin
                sel_o       = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = func3_i[2] ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                sel_o       = 4'b0011 << addr_lo_i;
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = func3_i[2] ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                misalign_o  = addr_lo_i[0];
            end
            default: misalign_o = |addr_lo_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: request/grant/response FSM with timeout, Execute stall
// generation and the valid-qualified WriteBack register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_ex_valid,
    input  logic [31:0]           i_result,
    input  logic [31:0]           i_data_store,
    input  logic [31:0]           i_pc,
    input  logic [2:0]            i_func3,
    input  logic [4:0]            i_rd,
    input  logic [6:0]            i_opcode,
    output logic                  o_stall,
    output logic                  o_wb_valid,
    output logic [4:0]            o_wb_rd,
    output logic [6:0]            o_opcode,
    output logic [31:0]           o_wb_data,
    output logic                  o_exc,
    output logic [3:0]            o_exc_cause,
    output logic                  o_req,
    input  logic                  i_gnt,
    output logic                  o_wr_en,
    output logic [3:0]            o_sel,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_wdata,
    input  logic                  i_rvalid,
    input  logic [31:0]           i_rdata,
    input  logic                  i_bus_err
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    wb_t           wb_q, wb_d;
    logic          wb_valid_q;
    logic          is_load, is_store, misalign, mem_go, timeout, retire;
    logic [31:0]   load_data;

    assign is_load  = (i_opcode == OPC_LOAD)  && load_f3_ok(i_func3);
    assign is_store = (i_opcode == OPC_STORE) && store_f3_ok(i_func3);

    lsu_align u_align (
        .func3_i     (i_func3),
        .addr_lo_i   (i_result[1:0]),
        .store_data_i(i_data_store),
        .rdata_i     (i_rdata),
        .sel_o       (o_sel),
        .wdata_o     (o_wdata),
        .load_data_o (load_data),
        .misalign_o  (misalign)
    );

    assign mem_go  = i_ex_valid && (is_load || is_store) && !misalign;
    // Fires on the cycle the counter would reach TIMEOUT_CYCLES.
    assign timeout = (TIMEOUT_CYCLES != 0) && (state_q != ST_IDLE) &&
                     (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    assign o_addr  = {i_result[ADDR_WIDTH-1:2], 2'b00};
    assign o_wr_en = is_store;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        o_req   = 1'b0;
        o_stall = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (mem_go) begin
                    o_req   = 1'b1;
                    o_stall = 1'b1;
                    state_d = i_gnt ? ST_RSP : ST_REQ;
                end else if (i_ex_valid) begin
                    retire = 1'b1;
                end
            end
            ST_REQ: begin
                tcnt_d = tcnt_q + TW'(1);
                if (timeout) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else begin
                    o_req   = 1'b1;
                    o_stall = 1'b1;
                    if (i_gnt) state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                tcnt_d = tcnt_q + TW'(1);
                if (i_rvalid || timeout) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_d        = '0;
        wb_d.rd     = i_rd;
        wb_d.opcode = i_opcode;
        wb_d.data   = i_result;
        if (state_q == ST_IDLE) begin
            if ((is_load || is_store) && misalign) begin
                wb_d.exc   = 1'b1;
                wb_d.cause = is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                wb_d.data  = '0;
            end else if (i_opcode == OPC_JAL || i_opcode == OPC_JALR) begin
                wb_d.data = i_pc + 32'd4;
            end
        end else if (state_q == ST_RSP && i_rvalid && !i_bus_err) begin
            wb_d.data = is_store ? 32'd0 : load_data;
        end else begin
            // Bus error or timeout: access fault.
            wb_d.exc   = 1'b1;
            wb_d.cause = is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            wb_d.data  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            wb_valid_q <= retire;
            if (retire) wb_q <= wb_d;
        end
    end

    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd     = wb_q.rd;
    assign o_opcode    = wb_q.opcode;
    assign o_wb_data   = wb_q.data;
    assign o_exc       = wb_q.exc;
    assign o_exc_cause = wb_q.cause;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a driver plays Execute and data memory,
// a monitor compares every WriteBack entry against a queued reference result.
module tb_mem_stage_lsu;
    localparam int TO = 4;
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, OP = 7'b0110011;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_ex_valid = 1'b0, i_gnt = 1'b0, i_rvalid = 1'b0, i_bus_err = 1'b0;
    logic [31:0] i_result = '0, i_data_store = '0, i_pc = '0, i_rdata = '0;
    logic [2:0]  i_func3 = '0;
    logic [4:0]  i_rd = '0;
    logic [6:0]  i_opcode = '0;
    logic        o_stall, o_wb_valid, o_exc, o_req, o_wr_en;
    logic [4:0]  o_wb_rd;
    logic [6:0]  o_opcode;
    logic [31:0] o_wb_data, o_wdata, o_addr;
    logic [3:0]  o_exc_cause, o_sel;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .i_ex_valid(i_ex_valid), .i_result(i_result),
        .i_data_store(i_data_store), .i_pc(i_pc), .i_func3(i_func3), .i_rd(i_rd),
        .i_opcode(i_opcode), .o_stall(o_stall), .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd),
        .o_opcode(o_opcode), .o_wb_data(o_wb_data), .o_exc(o_exc), .o_exc_cause(o_exc_cause),
        .o_req(o_req), .i_gnt(i_gnt), .o_wr_en(o_wr_en), .o_sel(o_sel), .o_addr(o_addr),
        .o_wdata(o_wdata), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_bus_err(i_bus_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_ld(input logic [6:0] opc, input logic [2:0] f3);
        return opc == LOAD && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    endfunction

    function automatic bit is_st(input logic [6:0] opc, input logic [2:0] f3);
        return opc == STORE && f3 <= 2;
    endfunction

    // Reference: byte-level arithmetic straight from the ISA rules.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [31:0] res, input logic [31:0] pc,
                                   input logic [4:0] rd, input bit done, input bit err,
                                   input logic [31:0] rdata);
        exp_t e;
        bit ld, sw;
        int size, off;
        longint unsigned u;
        longint s;
        ld = is_ld(opc, f3);
        sw = is_st(opc, f3);
        size = 1 << f3[1:0];
        off = int'(res % 4);
        e.rd = rd; e.opc = opc; e.exc = 1'b0; e.cause = 4'd0; e.data = res;
        if (!ld && !sw) begin
            if (opc == JAL || opc == JALR) e.data = pc + 32'd4;
        end else if (res % size != 0) begin
            e.exc = 1'b1; e.cause = sw ? 4'd6 : 4'd4; e.data = '0;
        end else if (!done || err) begin
            e.exc = 1'b1; e.cause = sw ? 4'd7 : 4'd5; e.data = '0;
        end else if (sw) begin
            e.data = '0;
        end else begin
            u = 64'(rdata);
            u = (u >> (8 * off)) % (64'd1 << (8 * size));
            s = longint'(u);
            if (!f3[2] && size < 4 && u >= (64'd1 << (8 * size - 1)))
                s = s - (longint'(1) << (8 * size));
            e.data = s[31:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] rep(input logic [31:0] st, input int size);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = st[8*(i % size) +: 8];
        return w;
    endfunction

    // Present one instruction; g = cycles before grant, r = cycles from grant to response.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] st, input logic [31:0] pc, input logic [4:0] rd,
                         input int g, input int r, input bit err, input logic [31:0] rdata);
        bit ld, sw, mem, done, ereq;
        int size, retc, selv;
        ld = is_ld(opc, f3);
        sw = is_st(opc, f3);
        size = 1 << f3[1:0];
        mem = (ld || sw) && (res % size == 0);
        done = mem && g < TO && g + r <= TO;
        retc = !mem ? 0 : (done ? g + r : TO);
        selv = ((1 << size) - 1) << (res % 4);
        sbq.push_back(model(opc, f3, res, pc, rd, done, err, rdata));
        i_ex_valid = 1'b1; i_opcode = opc; i_func3 = f3; i_result = res;
        i_data_store = st; i_pc = pc; i_rd = rd;
        for (int c = 0; c <= retc; c++) begin
            i_gnt = mem && c == g;
            i_rvalid = mem && c == g + r;
            i_rdata = (c == g + r) ? rdata : $urandom;
            i_bus_err = (c == g + r) ? err : 1'($urandom);
            @(negedge clk);
            ereq = mem && c <= g && c < TO;
            chk("req", 32'(o_req), 32'(ereq));
            chk("stall", 32'(o_stall), 32'(c < retc));
            if (ereq) begin
                chk("addr", o_addr, res & ~32'd3);
                chk("wr_en", 32'(o_wr_en), 32'(sw));
                chk("sel", 32'(o_sel), 32'(selv[3:0]));
                if (sw) chk("wdata", o_wdata, rep(st, size));
            end
            @(posedge clk); #1;
        end
        i_ex_valid = 1'b0; i_gnt = 1'b0; i_rvalid = 1'b0;
        i_result = $urandom; i_opcode = 7'($urandom);
    endtask

    always @(negedge clk) begin
        if (o_wb_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL wb_unexpected: o_wb_valid=1 rd=%0d data=%h, expected no entry at %0t",
                         o_wb_rd, o_wb_data, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
                chk("wb_opcode", 32'(o_opcode), 32'(e.opc));
                chk("wb_data", o_wb_data, e.data);
                chk("wb_exc", 32'(o_exc), 32'(e.exc));
                chk("wb_cause", 32'(o_exc_cause), 32'(e.cause));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wb_valid"}, 32'(o_wb_valid), 0);
        chk({tag, "_req"}, 32'(o_req), 0);
        chk({tag, "_stall"}, 32'(o_stall), 0);
        chk({tag, "_exc"}, 32'(o_exc), 0);
        chk({tag, "_wb_rd"}, 32'(o_wb_rd), 0);
        chk({tag, "_wb_data"}, o_wb_data, 0);
        chk({tag, "_opcode"}, 32'(o_opcode), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        issue(OP, 3'd0, 32'h1234, 32'h0, 32'h100, 5'd1, 0, 0, 0, 32'h0);
        issue(STORE, 3'd0, 32'h103, 32'h123456AB, 32'h104, 5'd2, 0, 1, 0, 32'h0);
        issue(LOAD, 3'd0, 32'h102, 32'h0, 32'h108, 5'd3, 0, 1, 0, 32'h0080FF00);
        issue(LOAD, 3'd4, 32'h102, 32'h0, 32'h10C, 5'd4, 0, 1, 0, 32'h0080FF00);
        issue(LOAD, 3'd1, 32'h102, 32'h0, 32'h110, 5'd5, 0, 1, 0, 32'h0080FF00);
        issue(LOAD, 3'd2, 32'h201, 32'h0, 32'h114, 5'd6, 0, 1, 0, 32'h0);
        issue(STORE, 3'd1, 32'h301, 32'hBEEF, 32'h118, 5'd7, 0, 1, 0, 32'h0);
        issue(LOAD, 3'd2, 32'h400, 32'h0, 32'h11C, 5'd8, 3, 1, 1, 32'hDEADBEEF);
        issue(LOAD, 3'd2, 32'h404, 32'h0, 32'h120, 5'd9, 99, 1, 0, 32'h0);
        issue(STORE, 3'd2, 32'h408, 32'h55AA55AA, 32'h124, 5'd10, 99, 1, 0, 32'h0);
        issue(JAL, 3'd0, 32'h9000, 32'h0, 32'h128, 5'd11, 0, 0, 0, 32'h0);
        issue(LOAD, 3'd5, 32'h502, 32'h0, 32'h12C, 5'd12, 1, 2, 0, 32'h8001_7FFF);
        idle(3);

        // Reset while the response is outstanding; a late response must be ignored.
        i_ex_valid = 1'b1; i_opcode = LOAD; i_func3 = 3'd2; i_result = 32'h600; i_rd = 5'd13;
        i_gnt = 1'b1;
        @(posedge clk); #1;
        i_gnt = 1'b0;
        @(negedge clk);
        chk("rsp_stall", 32'(o_stall), 1);
        @(posedge clk); #1;
        rst_n = 1'b0; i_ex_valid = 1'b0;
        #1;
        chk_zero("midreset");
        idle(1);
        rst_n = 1'b1;
        idle(1);
        i_rvalid = 1'b1; i_rdata = 32'h1111_2222;
        idle(1);
        i_rvalid = 1'b0;
        idle(2);
        @(negedge clk);
        chk("late_rvalid_ignored", 32'(o_wb_valid), 0);
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            logic [6:0] opc;
            logic [2:0] f3;
            int g, r, k;
            k = int'($urandom % 6);
            f3 = 3'($urandom % 3);
            case (k)
                0, 1: begin opc = LOAD; f3 = 3'($urandom % 5); if (f3 == 3) f3 = 3'd4; end
                2: opc = STORE;
                3: opc = JAL;
                4: opc = JALR;
                default: opc = OP;
            endcase
            g = int'($urandom % 3);
            r = 1 + int'($urandom % (3 - g));
            if ($urandom % 12 == 0) g = 99;
            issue(opc, f3, $urandom, $urandom, $urandom, 5'($urandom), g, r,
                  ($urandom % 5) == 0, $urandom);
            if ($urandom % 2 == 0) idle(1);
        end
        idle(3);
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
